// File: rtl/robot_pkg.sv
// Shared encodings for the robot motion interface and the command scheduler.
package robot_pkg;

    localparam logic [2:0] MV_STOP  = 3'b000;
    localparam logic [2:0] MV_FWD   = 3'b111;
    localparam logic [2:0] MV_LEFT  = 3'b101;
    localparam logic [2:0] MV_RIGHT = 3'b110;
    localparam logic [2:0] MV_BACK  = 3'b011;

    // ST_OBST is the single stop cycle between an obstacle hit and backing up;
    // ST_ABORT is the single stop cycle between an enable drop and power-down.
    localparam logic [3:0] ST_OFF      = 4'd0;
    localparam logic [3:0] ST_PWR_UP   = 4'd1;
    localparam logic [3:0] ST_IDLE     = 4'd2;
    localparam logic [3:0] ST_EXEC     = 4'd3;
    localparam logic [3:0] ST_OBST     = 4'd4;
    localparam logic [3:0] ST_RET_BACK = 4'd5;
    localparam logic [3:0] ST_RET_TURN = 4'd6;
    localparam logic [3:0] ST_ABORT    = 4'd7;
    localparam logic [3:0] ST_PWR_DN   = 4'd8;

    localparam logic SRC_RC   = 1'b0;
    localparam logic SRC_AUTO = 1'b1;

endpackage

// File: rtl/sched_hold_timer.sv
// Loadable down-counter that times how long a move is held on the robot.
module sched_hold_timer #(
    parameter int DUR_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic [DUR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [DUR_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Done on the last held cycle; an idle zero count also reads as done.
    assign done_o = (count_q <= DUR_W'(1));

endmodule

// File: rtl/robot_cmd_sched.sv
// Arbitrates RC/AUTO motion requests, sequences motor power and inserts an
// automatic back-then-turn retreat when a forward move hits an obstacle.
module robot_cmd_sched
    import robot_pkg::*;
#(
    parameter int DUR_W    = 8,
    parameter int BACK_CYC = 16,
    parameter int TURN_CYC = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             enable_i,
    input  logic             motor_status_i,
    input  logic             tracker_status_i,
    output logic             motor_on_o,
    output logic [2:0]       move_o,
    input  logic             rc_valid_i,
    input  logic [2:0]       rc_cmd_i,
    input  logic [DUR_W-1:0] rc_dur_i,
    output logic             rc_ready_o,
    input  logic             auto_valid_i,
    input  logic [2:0]       auto_cmd_i,
    input  logic [DUR_W-1:0] auto_dur_i,
    output logic             auto_ready_o,
    output logic             busy_o,
    output logic             src_o,
    output logic             retreat_o
);

    logic [3:0]       state_q, state_d;
    logic [2:0]       cmd_q, cmd_d;
    logic             src_q, src_d;
    logic             tmr_load;
    logic [DUR_W-1:0] tmr_val;
    logic             tmr_done;
    logic             rc_hs, auto_hs;
    logic             motor_on_d, busy_d, retreat_d, src_out_d;
    logic [2:0]       move_d;

    function automatic logic [DUR_W-1:0] clamp_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign rc_ready_o   = (state_q == ST_IDLE) || ((state_q == ST_EXEC) && (src_q == SRC_AUTO));
    assign auto_ready_o = (state_q == ST_IDLE);
    assign rc_hs        = rc_valid_i & rc_ready_o;
    assign auto_hs      = auto_valid_i & auto_ready_o;

    sched_hold_timer #(.DUR_W(DUR_W)) u_timer (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // In EXEC an RC handshake is honoured before the obstacle check so that a
    // request seeing rc_ready_o high is never silently dropped.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        src_d    = src_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_OFF: begin
                if (enable_i) state_d = ST_PWR_UP;
            end
            ST_PWR_UP: begin
                if (!enable_i)          state_d = ST_OFF;
                else if (motor_status_i) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!enable_i) begin
                    state_d = ST_PWR_DN;
                end else if (rc_hs) begin
                    cmd_d    = rc_cmd_i;
                    src_d    = SRC_RC;
                    tmr_load = 1'b1;
                    tmr_val  = clamp_dur(rc_dur_i);
                    state_d  = ST_EXEC;
                end else if (auto_hs) begin
                    cmd_d    = auto_cmd_i;
                    src_d    = SRC_AUTO;
                    tmr_load = 1'b1;
                    tmr_val  = clamp_dur(auto_dur_i);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!enable_i) begin
                    state_d = ST_ABORT;
                end else if (rc_hs) begin
                    cmd_d    = rc_cmd_i;
                    src_d    = SRC_RC;
                    tmr_load = 1'b1;
                    tmr_val  = clamp_dur(rc_dur_i);
                end else if ((cmd_q == MV_FWD) && tracker_status_i) begin
                    state_d = ST_OBST;
                end else if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OBST: begin
                if (!enable_i) begin
                    state_d = ST_ABORT;
                end else begin
                    tmr_load = 1'b1;
                    tmr_val  = DUR_W'(BACK_CYC);
                    state_d  = ST_RET_BACK;
                end
            end
            ST_RET_BACK: begin
                if (!enable_i) begin
                    state_d = ST_ABORT;
                end else if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = DUR_W'(TURN_CYC);
                    state_d  = ST_RET_TURN;
                end
            end
            ST_RET_TURN: begin
                if (!enable_i)     state_d = ST_ABORT;
                else if (tmr_done) state_d = ST_IDLE;
            end
            ST_ABORT: begin
                state_d = ST_PWR_DN;
            end
            ST_PWR_DN: begin
                if (!motor_status_i) state_d = ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Outputs are registered images of the next state so they line up with it.
    always_comb begin
        motor_on_d = (state_d != ST_OFF) && (state_d != ST_PWR_DN);
        busy_d     = (state_d == ST_EXEC) || (state_d == ST_OBST) ||
                     (state_d == ST_RET_BACK) || (state_d == ST_RET_TURN);
        retreat_d  = (state_d == ST_OBST) || (state_d == ST_RET_BACK) ||
                     (state_d == ST_RET_TURN);
        src_out_d  = (state_d == ST_EXEC) ? src_d : SRC_RC;
        case (state_d)
            ST_EXEC:     move_d = cmd_d;
            ST_RET_BACK: move_d = MV_BACK;
            ST_RET_TURN: move_d = MV_RIGHT;
            default:     move_d = MV_STOP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_OFF;
            cmd_q      <= MV_STOP;
            src_q      <= SRC_RC;
            motor_on_o <= 1'b0;
            move_o     <= MV_STOP;
            busy_o     <= 1'b0;
            retreat_o  <= 1'b0;
            src_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            src_q      <= src_d;
            motor_on_o <= motor_on_d;
            move_o     <= move_d;
            busy_o     <= busy_d;
            retreat_o  <= retreat_d;
            src_o      <= src_out_d;
        end
    end

endmodule

// File: tb/tb_robot_cmd_sched.sv
// Testbench for robot_cmd_sched: directed scenarios plus random traffic checked
// against a queue-based model where each accepted activity becomes a list of moves.
module tb_robot_cmd_sched;

    localparam int DUR_W    = 8;
    localparam int BACK_CYC = 16;
    localparam int TURN_CYC = 8;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             enable_i = 1'b0;
    logic             motor_status_i = 1'b0;
    logic             tracker_status_i = 1'b0;
    logic             motor_on_o;
    logic [2:0]       move_o;
    logic             rc_valid_i = 1'b0;
    logic [2:0]       rc_cmd_i = 3'b000;
    logic [DUR_W-1:0] rc_dur_i = '0;
    logic             rc_ready_o;
    logic             auto_valid_i = 1'b0;
    logic [2:0]       auto_cmd_i = 3'b000;
    logic [DUR_W-1:0] auto_dur_i = '0;
    logic             auto_ready_o;
    logic             busy_o;
    logic             src_o;
    logic             retreat_o;

    always #5 clk_i = ~clk_i;

    robot_cmd_sched #(.DUR_W(DUR_W), .BACK_CYC(BACK_CYC), .TURN_CYC(TURN_CYC)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .enable_i         (enable_i),
        .motor_status_i   (motor_status_i),
        .tracker_status_i (tracker_status_i),
        .motor_on_o       (motor_on_o),
        .move_o           (move_o),
        .rc_valid_i       (rc_valid_i),
        .rc_cmd_i         (rc_cmd_i),
        .rc_dur_i         (rc_dur_i),
        .rc_ready_o       (rc_ready_o),
        .auto_valid_i     (auto_valid_i),
        .auto_cmd_i       (auto_cmd_i),
        .auto_dur_i       (auto_dur_i),
        .auto_ready_o     (auto_ready_o),
        .busy_o           (busy_o),
        .src_o            (src_o),
        .retreat_o        (retreat_o)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Model: power phase, current activity, and the moves still to be shown.
    typedef enum int {P_OFF, P_UP, P_ON, P_DOWN} pwr_t;
    typedef enum int {A_NONE, A_CMD, A_RETREAT, A_ABORT} act_t;
    pwr_t       mPwr;
    act_t       mAct;
    logic       mSrc;
    logic [2:0] mCmd;
    int         mPlan[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mPwr = P_OFF;
        mAct = A_NONE;
        mSrc = 1'b0;
        mCmd = 3'b000;
        mPlan = {};
    endfunction

    function automatic void startCmd(input logic [2:0] c, input logic [DUR_W-1:0] d, input logic s);
        int n;
        n = (d == 0) ? 1 : int'(d);
        mAct = A_CMD;
        mCmd = c;
        mSrc = s;
        mPlan = {};
        for (int i = 0; i < n; i++) mPlan.push_back(int'(c));
    endfunction

    function automatic void startAbort();
        mAct = A_ABORT;
        mPlan = {};
        mPlan.push_back(0);
    endfunction

    function automatic void startRetreat();
        mAct = A_RETREAT;
        mPlan = {};
        mPlan.push_back(0);
        for (int i = 0; i < BACK_CYC; i++) mPlan.push_back(3);
        for (int i = 0; i < TURN_CYC; i++) mPlan.push_back(6);
    endfunction

    function automatic void consumeOne();
        int t;
        t = mPlan.pop_front();
        if (mPlan.size() == 0) mAct = A_NONE;
    endfunction

    function automatic logic expRcReady();
        return ((mPwr == P_ON) && (mAct == A_NONE)) || ((mAct == A_CMD) && mSrc);
    endfunction

    function automatic logic expAutoReady();
        return (mPwr == P_ON) && (mAct == A_NONE);
    endfunction

    function automatic void modelStep();
        case (mPwr)
            P_OFF:  if (enable_i) mPwr = P_UP;
            P_UP:   if (!enable_i) mPwr = P_OFF; else if (motor_status_i) mPwr = P_ON;
            P_DOWN: if (!motor_status_i) mPwr = P_OFF;
            P_ON: begin
                case (mAct)
                    A_NONE: begin
                        if (!enable_i)         mPwr = P_DOWN;
                        else if (rc_valid_i)   startCmd(rc_cmd_i, rc_dur_i, 1'b0);
                        else if (auto_valid_i) startCmd(auto_cmd_i, auto_dur_i, 1'b1);
                    end
                    A_CMD: begin
                        if (!enable_i)                              startAbort();
                        else if (rc_valid_i && mSrc)                startCmd(rc_cmd_i, rc_dur_i, 1'b0);
                        else if (mCmd == 3'b111 && tracker_status_i) startRetreat();
                        else                                        consumeOne();
                    end
                    A_RETREAT: begin
                        if (!enable_i) startAbort();
                        else           consumeOne();
                    end
                    default: begin
                        mAct = A_NONE;
                        mPlan = {};
                        mPwr = P_DOWN;
                    end
                endcase
            end
            default: mPwr = P_OFF;
        endcase
    endfunction

    task automatic checkAll();
        logic [2:0] expMove;
        expMove = (mAct != A_NONE && mPlan.size() > 0) ? 3'(mPlan[0]) : 3'b000;
        checkOutput("move", 32'(move_o), 32'(expMove));
        checkOutput("motor_on", 32'(motor_on_o), 32'(mPwr == P_UP || mPwr == P_ON));
        checkOutput("busy", 32'(busy_o), 32'(mAct == A_CMD || mAct == A_RETREAT));
        checkOutput("retreat", 32'(retreat_o), 32'(mAct == A_RETREAT));
        checkOutput("src", 32'(src_o), 32'((mAct == A_CMD) ? mSrc : 1'b0));
        checkOutput("rc_ready", 32'(rc_ready_o), 32'(expRcReady()));
        checkOutput("auto_ready", 32'(auto_ready_o), 32'(expAutoReady()));
    endtask

    task automatic applyStimulus(input logic en, input logic ms, input logic tr,
                                 input logic rv, input logic [2:0] rc, input logic [DUR_W-1:0] rd,
                                 input logic av, input logic [2:0] ac, input logic [DUR_W-1:0] ad);
        @(negedge clk_i);
        enable_i = en; motor_status_i = ms; tracker_status_i = tr;
        rc_valid_i = rv; rc_cmd_i = rc; rc_dur_i = rd;
        auto_valid_i = av; auto_cmd_i = ac; auto_dur_i = ad;
        #1;
        checkOutput("pre_rc_ready", 32'(rc_ready_o), 32'(expRcReady()));
        checkOutput("pre_auto_ready", 32'(auto_ready_o), 32'(expAutoReady()));
        @(posedge clk_i);
        modelStep();
        #1;
        checkAll();
    endtask

    task automatic idleCycles(input int n, input logic en, input logic ms);
        for (int i = 0; i < n; i++) applyStimulus(en, ms, 1'b0, 1'b0, 3'b000, '0, 1'b0, 3'b000, '0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_move", 32'(move_o), 32'd0);
        checkOutput("rst_motor_on", 32'(motor_on_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_retreat", 32'(retreat_o), 32'd0);
        checkOutput("rst_src", 32'(src_o), 32'd0);
        checkOutput("rst_rc_ready", 32'(rc_ready_o), 32'd0);
        checkOutput("rst_auto_ready", 32'(auto_ready_o), 32'd0);
    endtask

    initial begin
        logic en, ms;
        int   guard;
        modelReset();
        #1;
        checkResetOutputs();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Power-up with motor feedback arriving three cycles later.
        idleCycles(3, 1'b1, 1'b0);
        idleCycles(2, 1'b1, 1'b1);

        // Simultaneous requests: RC wins, AUTO keeps asking until accepted.
        applyStimulus(1, 1, 0, 1, 3'b101, 8'd4, 1, 3'b111, 8'd9);
        guard = 0;
        while (!(mAct == A_CMD && mSrc) && guard < 20) begin
            applyStimulus(1, 1, 0, 0, 3'b000, 8'd0, 1, 3'b111, 8'd9);
            guard++;
        end
        checkOutput("auto_accepted", 32'(mAct == A_CMD && mSrc), 32'd1);
        idleCycles(12, 1'b1, 1'b1);

        // RC preempts a running AUTO forward move.
        applyStimulus(1, 1, 0, 0, 3'b000, 8'd0, 1, 3'b111, 8'd20);
        idleCycles(4, 1'b1, 1'b1);
        applyStimulus(1, 1, 0, 1, 3'b011, 8'd2, 0, 3'b000, 8'd0);
        idleCycles(5, 1'b1, 1'b1);

        // Obstacle during RC forward triggers the retreat sequence.
        applyStimulus(1, 1, 0, 1, 3'b111, 8'd50, 0, 3'b000, 8'd0);
        idleCycles(9, 1'b1, 1'b1);
        applyStimulus(1, 1, 1, 0, 3'b000, 8'd0, 0, 3'b000, 8'd0);
        idleCycles(BACK_CYC + TURN_CYC + 4, 1'b1, 1'b1);

        // Zero duration is held for one cycle.
        applyStimulus(1, 1, 0, 0, 3'b000, 8'd0, 1, 3'b110, 8'd0);
        idleCycles(3, 1'b1, 1'b1);

        // Enable drop mid-command, power down, then power back up.
        applyStimulus(1, 1, 0, 1, 3'b101, 8'd10, 0, 3'b000, 8'd0);
        idleCycles(3, 1'b1, 1'b1);
        idleCycles(3, 1'b0, 1'b1);
        idleCycles(2, 1'b0, 1'b0);
        idleCycles(2, 1'b1, 1'b0);
        idleCycles(2, 1'b1, 1'b1);

        // Random traffic.
        en = 1'b1;
        ms = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) ms = ~ms;
            applyStimulus(en, ms, ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom),
                          DUR_W'($urandom_range(0, 12)),
                          ($urandom_range(0, 1) == 0),
                          ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom),
                          DUR_W'($urandom_range(0, 12)));
        end

        // Asynchronous reset in the middle of a command.
        guard = 0;
        while (mAct != A_CMD && guard < 200) begin
            applyStimulus(1, 1, 0, 1, 3'b101, 8'd30, 0, 3'b000, 8'd0);
            guard++;
        end
        checkOutput("reach_exec", 32'(mAct == A_CMD), 32'd1);
        idleCycles(2, 1'b1, 1'b1);
        @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        #1;
        checkResetOutputs();
        modelReset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        idleCycles(4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/robot_cmd_sched.md
Name: robot_cmd_sched

Overview:
Command scheduler in front of the robot motion FSM. It arbitrates motion requests from two requesters, the remote-control (RC) link and the autonomous route player (AUTO), and holds each accepted command on move_o for a programmed number of cycles. It also sequences motor power-up and power-down. When the robot reports a forward obstacle, it inserts an automatic retreat manoeuvre (back, then turn right).

Parameters:
DUR_W, 8, width of command duration fields and of the hold counter
BACK_CYC, 16, cycles move_o is held at back (011) during retreat; must be ≥1 and < 2^DUR_W
TURN_CYC, 8, cycles move_o is held at turn right (110) during retreat; must be ≥1 and < 2^DUR_W

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
enable_i  in  1  level; 1 = robot should be powered
motor_status_i  in  1  robot motor-running indication
tracker_status_i  in  1  robot obstacle pulse
motor_on_o  out  1  drives robot motor_on_i
move_o  out  3  drives robot move_i (000 stop, 111 fwd, 101 left, 110 right, 011 back)
rc_valid_i  in  1  RC request valid
rc_cmd_i  in  3  RC command
rc_dur_i  in  DUR_W  RC hold cycles
rc_ready_o  out  1  RC request accepted when valid&ready
auto_valid_i  in  1  AUTO request valid
auto_cmd_i  in  3  AUTO command
auto_dur_i  in  DUR_W  AUTO hold cycles
auto_ready_o  out  1  AUTO request accepted when valid&ready
busy_o  out  1  a command or retreat is in progress
src_o  out  1  source of the active command (0 RC, 1 AUTO)
retreat_o  out  1  retreat in progress

Behaviour:
- Reset: rstn_i is asynchronous and active-low; clock is clk_i. During reset all outputs are 0, state = OFF, counter = 0. All outputs are registered.
- Ready signals are combinational from state only: rc_ready_o = 1 in IDLE and in EXEC with src=AUTO; auto_ready_o = 1 in IDLE only. There is no dependence on valid.
- OFF: motor_on_o = 0, move_o = 000. If enable_i, go to PWR_UP and set motor_on_o = 1.
- PWR_UP: hold motor_on_o = 1. When motor_status_i = 1, go to IDLE. If enable_i drops, go to OFF.
- IDLE: move_o = 000.
  - If enable_i = 0, go to PWR_DN.
  - Else if RC handshake, latch rc_cmd/rc_dur, src = 0, go to EXEC.
  - Else if AUTO handshake, latch AUTO, src = 1, go to EXEC.
  - Fixed priority: RC > AUTO.
- EXEC: move_o = latched cmd from the cycle after accept. The counter loads max(dur, 1), so dur = 0 is treated as 1. Decrement every cycle; at 1, return to IDLE. move_o is therefore non-zero for exactly max(dur, 1) cycles.
- Preemption: an RC handshake while src = AUTO replaces the cmd and counter in the same cycle and sets src = 0. move_o switches the next cycle with no 000 gap. AUTO is never notified of the abort beyond observing src_o.
- Obstacle: tracker_status_i = 1 in EXEC while cmd = 111 gives move_o = 000 next cycle, then RETREAT_BACK.
- RETREAT_BACK: move_o = 011 for BACK_CYC cycles, then RETREAT_TURN.
- RETREAT_TURN: move_o = 110 for TURN_CYC cycles, then IDLE.
- During retreat: retreat_o = 1 and busy_o = 1. Both ready signals are 0.
- tracker_status_i is ignored outside EXEC-forward.
- enable_i = 0 in EXEC or retreat aborts immediately: move_o = 000 next cycle, then PWR_DN.
- PWR_DN: move_o = 000, motor_on_o = 0. Wait until motor_status_i = 0, then OFF. If enable_i reasserts before then, remain in PWR_DN until OFF is reached.
- busy_o = 1 in EXEC, RETREAT_*.
- Unknown or illegal cmd codes are passed through unchanged; the robot treats them as stop.
- Illegal state encodings recover to OFF.

Decomposition:
- Shared package robot_pkg holds:
  - move encodings MV_STOP/MV_FWD/MV_LEFT/MV_RIGHT/MV_BACK (3-bit), also adopted by the robot block;
  - scheduler state encoding (4-bit localparams);
  - SRC_RC/SRC_AUTO constants.
- One sub-module, sched_hold_timer: a loadable down-counter with load value, load strobe and done flag, width DUR_W.
- It is shared by EXEC and both retreat phases.

Test Plan:
- Power-up: enable_i = 1, motor_status_i rises 3 cycles later → motor_on_o = 1 from cycle 1, IDLE, rc_ready_o = auto_ready_o = 1. Drop enable_i → motor_on_o = 0, OFF after motor_status_i = 0.
- Simultaneous requests in IDLE: RC cmd 101 dur 4, AUTO cmd 111 dur 9 → RC accepted, src_o = 0, move_o = 101 for exactly 4 cycles then 000. AUTO accepted on the next IDLE cycle.
- Preemption: AUTO 111 dur 20 running, RC 011 dur 2 at cycle 5 → move_o = 011 from cycle 6 for 2 cycles, src_o = 0, then 000.
- Obstacle: RC 111 dur 50, tracker pulse at cycle 10 → one 000 cycle, then 011 × BACK_CYC, then 110 × TURN_CYC, retreat_o high throughout, readies low, then IDLE.
- dur = 0: AUTO 110 dur 0 → move_o = 110 for exactly 1 cycle.
- Reset mid-EXEC: assert rstn_i = 0 asynchronously mid-command → all outputs 0 immediately; after release, state = OFF and no command resumes.
